// File: rtl/branch_resolve_queue_pkg.sv
`default_nettype none
// ============================================================================
// branch_resolve_queue_pkg : shared types and helpers for the resolve queue
// Rev 1.0
// ============================================================================
package branch_resolve_queue_pkg;

  localparam int MAX_ADDRESS_BITS = 16;
  localparam int CNT_BITS_DEF     = 16;

  // Address field is sized for the widest supported table; upper bits stay zero
  typedef struct packed {
    logic [MAX_ADDRESS_BITS-1:0] address;
    logic                        prediction;
  } brq_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// branch_resolve_queue_if : issue / resolve / training bus of the resolve queue
// Rev 1.0
// ============================================================================
interface branch_resolve_queue_if #(
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 4,
  parameter int CNT_BITS     = branch_resolve_queue_pkg::CNT_BITS_DEF
);

  logic                    issue_valid;
  logic [ADDRESS_BITS-1:0] issue_address;
  logic                    issue_prediction;
  logic                    issue_ready;
  logic                    resolve_valid;
  logic                    resolve_taken;
  logic                    upd_valid;
  logic [ADDRESS_BITS-1:0] upd_address;
  logic                    upd_actual;
  logic                    mispredict;
  logic                    flush;
  logic                    resolve_err;
  logic [branch_resolve_queue_pkg::occ_width(DEPTH)-1:0] occupancy;
  logic [CNT_BITS-1:0]     branch_count;
  logic [CNT_BITS-1:0]     mispredict_count;

  modport master (
    output issue_valid, issue_address, issue_prediction, resolve_valid, resolve_taken,
    input  issue_ready, upd_valid, upd_address, upd_actual, mispredict, flush,
    input  resolve_err, occupancy, branch_count, mispredict_count
  );

  modport slave (
    input  issue_valid, issue_address, issue_prediction, resolve_valid, resolve_taken,
    output issue_ready, upd_valid, upd_address, upd_actual, mispredict, flush,
    output resolve_err, occupancy, branch_count, mispredict_count
  );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue_pred_fifo.sv
`default_nettype none
// ============================================================================
// pred_fifo : circular in-flight prediction store with flush-to-head
// Rev 1.0
// ============================================================================
module pred_fifo
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         push_i,
  input  wire brq_entry_t                   push_entry_i,
  input  wire logic                         pop_i,
  input  wire logic                         flush_i,
  output brq_entry_t                        head_entry_o,
  output logic [occ_width(DEPTH)-1:0]       occupancy_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_occ_w = occ_width(DEPTH);

  logic [c_ptr_w-1:0] head_q, head_d;
  logic [c_ptr_w-1:0] tail_q, tail_d;
  logic [c_occ_w-1:0] occ_q, occ_d;
  brq_entry_t         mem_q [DEPTH];

  // Flush collapses the queue onto the post-pop head in the same edge
  always_comb begin
    head_d = head_q + c_ptr_w'(pop_i);
    tail_d = tail_q + c_ptr_w'(push_i);
    occ_d  = occ_q + c_occ_w'(push_i) - c_occ_w'(pop_i);
    if (flush_i) begin
      tail_d = head_d;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign occupancy_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// branch_resolve_queue : compares in-order outcomes with queued predictions
// Rev 1.0
// ============================================================================
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 4,
  parameter int CNT_BITS     = CNT_BITS_DEF
) (
  input wire logic              clk,
  input wire logic              reset,
  branch_resolve_queue_if.slave bus
);

  localparam int                 c_occ_w = occ_width(DEPTH);
  localparam logic [c_occ_w-1:0] c_full  = c_occ_w'(DEPTH);

  brq_entry_t          w_push_entry;
  brq_entry_t          w_head_entry;
  logic [c_occ_w-1:0]  w_occ;
  logic                w_empty;
  logic                w_res_ok;
  logic                w_mis;
  logic                w_ready;
  logic                w_push;

  logic                    upd_valid_q, upd_valid_d;
  logic [ADDRESS_BITS-1:0] upd_address_q, upd_address_d;
  logic                    upd_actual_q, upd_actual_d;
  logic                    mispredict_q, mispredict_d;
  logic                    flush_q, flush_d;
  logic                    resolve_err_q, resolve_err_d;
  logic [CNT_BITS-1:0]     branch_cnt_q, branch_cnt_d;
  logic [CNT_BITS-1:0]     mis_cnt_q, mis_cnt_d;

  assign w_push_entry.address    = MAX_ADDRESS_BITS'(bus.issue_address);
  assign w_push_entry.prediction = bus.issue_prediction;

  assign w_empty  = (w_occ == '0);
  assign w_res_ok = bus.resolve_valid && !w_empty;
  assign w_mis    = w_res_ok && (bus.resolve_taken != w_head_entry.prediction);
  assign w_ready  = (w_occ != c_full) && !flush_q;
  // A same-edge issue is dropped on mispredict; upstream covers it with the flush
  assign w_push   = bus.issue_valid && w_ready && !w_mis;

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_res_ok),
    .flush_i      (w_mis),
    .head_entry_o (w_head_entry),
    .occupancy_o  (w_occ)
  );

  generate
    if (ADDRESS_BITS < MAX_ADDRESS_BITS) begin : g_addr_pad
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^w_head_entry.address[MAX_ADDRESS_BITS-1:ADDRESS_BITS];
    end
  endgenerate

  always_comb begin
    upd_valid_d   = w_res_ok;
    upd_address_d = upd_address_q;
    upd_actual_d  = upd_actual_q;
    mispredict_d  = w_mis;
    flush_d       = w_mis;
    resolve_err_d = bus.resolve_valid && w_empty;
    branch_cnt_d  = branch_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    if (w_res_ok) begin
      upd_address_d = w_head_entry.address[ADDRESS_BITS-1:0];
      upd_actual_d  = bus.resolve_taken;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_BITS'(1);
    end
    if (w_mis && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_valid_q   <= 1'b0;
      upd_address_q <= '0;
      upd_actual_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      flush_q       <= 1'b0;
      resolve_err_q <= 1'b0;
      branch_cnt_q  <= '0;
      mis_cnt_q     <= '0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_address_q <= upd_address_d;
      upd_actual_q  <= upd_actual_d;
      mispredict_q  <= mispredict_d;
      flush_q       <= flush_d;
      resolve_err_q <= resolve_err_d;
      branch_cnt_q  <= branch_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign bus.issue_ready      = w_ready;
  assign bus.upd_valid        = upd_valid_q;
  assign bus.upd_address      = upd_address_q;
  assign bus.upd_actual       = upd_actual_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.flush            = flush_q;
  assign bus.resolve_err      = resolve_err_q;
  assign bus.occupancy        = w_occ;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mis_cnt_q;

endmodule
`default_nettype wire
